rf_dump_reader: RTL and testbench
=================================

// Module: rf_dump_reader
// PURPOSE
//  Debug-side reader for the CPU register file. On a start pulse, walks the RF debug read
//  port (address out, async data in) over a register range and streams each
//  {address, data} pair out over a valid/ready interface, for the debug UART or trace buffer.
//  Consumes the port the RF exposes for debugging; never writes the RF.
// PARAMETERS
//  DATA_W     32  RF word width
//  ADDR_W     5   RF address width (32 registers)
//  FIRST_REG  0   first register dumped
//  LAST_REG   31  last register dumped; FIRST_REG <= LAST_REG < 2**ADDR_W
// PORTS
//  clk        in   1       clock, rising edge
//  rstn       in   1       asynchronous active-low reset
//  start      in   1       one-cycle request to begin a dump; ignored unless idle
//  abort      in   1       cancel dump in progress
//  busy       out  1       high from the cycle after an accepted start until back in IDLE
//  done       out  1       one-cycle pulse after the last beat is accepted
//  dbg_ra     out  ADDR_W  RF debug read address
//  dbg_rd     in   DATA_W  RF debug read data (combinational from dbg_ra)
//  out_valid  out  1       stream beat valid
//  out_ready  in   1       sink ready
//  out_addr   out  ADDR_W  register index of current beat
//  out_data   out  DATA_W  register value of current beat
//  out_last   out  1       current beat is LAST_REG
// BEHAVIOUR
//  Reset (rstn low, any time, async): state IDLE; busy, done, out_valid, out_last = 0;
//   dbg_ra, out_addr, out_data = 0. Dump in flight is dropped; no done pulse.
//  FSM states IDLE, LOAD, SEND, FIN:
//   IDLE: start=1 -> LOAD, dbg_ra <= FIRST_REG.
//   LOAD: out_data <= dbg_rd, out_addr <= dbg_ra, out_last <= (dbg_ra==LAST_REG),
//         out_valid <= 1 -> SEND.
//   SEND: out_valid && out_ready -> out_valid <= 0; if out_last -> FIN,
//         else dbg_ra <= dbg_ra+1 -> LOAD. Not ready -> stay, all out_* held stable.
//   FIN:  done = 1 for this cycle only -> IDLE.
//  Throughput: one beat per 2 cycles with out_ready tied high; full 32-reg dump is
//   64 cycles LOAD/SEND + 1 FIN cycle.
//  Data is sampled in LOAD; RF writes to a register after its LOAD cycle are not reflected
//   (no atomic snapshot). Register 0 always reads 0.
//  dbg_ra increments only on beat acceptance; never exceeds LAST_REG; no wrap-around.
//  abort=1 in LOAD/SEND/FIN: next state IDLE, out_valid <= 0, no done; abort wins over
//   a same-cycle handshake (that beat counts as not accepted). abort in IDLE: no effect.
//  start and abort in the same IDLE cycle: abort wins, stay IDLE.
//  start while busy: ignored, not queued.
//  busy = (state != IDLE). done never coincides with out_valid.
// TESTING
//  1 RF at power-on values, start, out_ready=1 -> 32 beats addr 0..31, addr2=0x2ffc,
//    addr3=0x1800, others 0, out_last only on addr 31, done 65 cycles after start.
//  2 Preload rk=0xA5000000+k, out_ready toggled 1-of-3 cycles -> all 32 beats correct,
//    out_addr/out_data stable during every stall, no beat duplicated or lost.
//  3 Assert abort while in SEND at addr 10 -> out_valid low next cycle, busy low,
//    no done; later start -> fresh dump begins at addr 0.
//  4 Drop rstn asynchronously mid-dump (between edges) -> all outputs 0 immediately;
//    release, start -> complete normal dump.
//  5 FIRST_REG=2, LAST_REG=3 -> exactly two beats {2,0x2ffc} {3,0x1800,last}; start
//    pulsed during dump ignored; done exactly once.
//  6 Write r5=0x1234 on the cycle after addr 5 LOAD -> beat 5 carries old value; next
//    dump carries 0x1234.

Source files
------------

// File: rtl/rf_dump_reader.sv
// Purpose: walks the RF debug read port over FIRST_REG..LAST_REG and streams {addr,data} beats.
// Latency: first beat valid 2 cycles after start, one beat per 2 cycles at full rate, done 1 cycle after last accept.
// Backpressure: beat held stable in SEND while out_ready is low; abort drops the pending beat.
module rf_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] dbg_ra,
    input  logic [DATA_W-1:0] dbg_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    state_t state, state_nxt;
    logic   accept;

    // abort beats a same-cycle handshake: the beat is treated as never delivered
    assign accept = out_valid && out_ready && !abort;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: if (start && !abort) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : SEND;
            SEND: begin
                if (abort)       state_nxt = IDLE;
                else if (accept) state_nxt = out_last ? FIN : LOAD;
            end
            FIN: begin
                state_nxt = IDLE;
                done      = !abort;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dbg_ra    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) dbg_ra <= FIRST_A;
                LOAD: begin
                    if (!abort) begin
                        out_data  <= dbg_rd;
                        out_addr  <= dbg_ra;
                        out_last  <= (dbg_ra == LAST_A);
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort || accept) out_valid <= 1'b0;
                    if (accept && !out_last) dbg_ra <= dbg_ra + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: full-range instance checked by a transaction-level model, plus a 2..3 range instance.
module tb_rf_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic busy, done, out_valid, out_last;
    logic [AW-1:0] dbg_ra, out_addr;
    logic [DW-1:0] dbg_rd, out_data;

    logic start2 = 1'b0, ready2 = 1'b1, abort2 = 1'b0;
    logic busy2, done2, valid2, last2;
    logic [AW-1:0] ra2, addr2;
    logic [DW-1:0] rd2, data2;

    logic [DW-1:0] rf   [32];
    logic [DW-1:0] snap [32];
    logic [DW-1:0] seen [32];

    assign dbg_rd = rf[dbg_ra];
    assign rd2    = rf[ra2];

    rf_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last));

    rf_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(2), .LAST_REG(3)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
        .dbg_ra(ra2), .dbg_rd(rd2), .out_valid(valid2), .out_ready(ready2),
        .out_addr(addr2), .out_data(data2), .out_last(last2));

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int rmode = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: expected address queue, RF snapshot taken at dump start
    logic m_busy = 1'b0, m_fin = 1'b0;
    int   q[$];
    logic prev_stall = 1'b0, hold_last;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic acc, last_acc, exp_done;
    int   ea;
    int   done_cnt = 0, done_cyc = 0, beat_cnt = 0, last_addr = 0;
    int   b2_n = 0, done2_cnt = 0;
    logic [AW-1:0] b2_addr [8];
    logic [DW-1:0] b2_data [8];
    logic          b2_last [8];

    always @(negedge clk) begin
        if (!rstn) begin
            m_busy = 1'b0; m_fin = 1'b0; prev_stall = 1'b0; q.delete();
        end else begin
            chk("busy", busy, m_busy);
            exp_done = m_fin && !abort;
            chk("done", done, exp_done);
            chk("done_with_valid", done && out_valid, 1'b0);
            chk("valid_while_idle", out_valid && !m_busy, 1'b0);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_addr", out_addr, hold_addr);
                chk("stall_data", out_data, hold_data);
                chk("stall_last", out_last, hold_last);
            end
            acc = out_valid && out_ready && !abort;
            last_acc = 1'b0;
            if (acc) begin
                if (q.size() == 0) chk("extra_beat", out_valid, 1'b0);
                else begin
                    ea = q.pop_front();
                    chk("beat_addr", out_addr, ea);
                    chk("beat_data", out_data, snap[ea]);
                    chk("beat_last", out_last, ea == 31);
                    seen[out_addr] = out_data;
                    last_addr = out_addr;
                    beat_cnt++;
                    last_acc = (ea == 31);
                end
            end
            prev_stall = out_valid && !out_ready && !abort;
            hold_addr = out_addr; hold_data = out_data; hold_last = out_last;
            if (m_busy && abort) begin
                m_busy = 1'b0; m_fin = 1'b0; q.delete();
            end else if (m_fin) begin
                m_busy = 1'b0; m_fin = 1'b0;
            end else if (last_acc) begin
                m_fin = 1'b1;
            end else if (!m_busy && start && !abort) begin
                m_busy = 1'b1;
                q.delete();
                for (int k = 0; k < 32; k++) q.push_back(k);
                snap = rf;
            end
            if (valid2 && ready2 && b2_n < 8) begin
                b2_addr[b2_n] = addr2; b2_data[b2_n] = data2; b2_last[b2_n] = last2;
                b2_n++;
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    int s_cyc;
    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk(name, done_cnt != d0, 1'b1);
    endtask

    int b0, d0;
    logic ok;

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = '0;
        rf[2] = 32'h2ffc;
        rf[3] = 32'h1800;
        for (int k = 0; k < 32; k++) seen[k] = '1;
        tick(); tick();
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
        chk("rst_ra", dbg_ra, 0);     chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        rstn = 1'b1;
        tick();

        // power-on dump, full rate
        b0 = beat_cnt;
        pulse_start();
        wait_done("t1_done_seen", 200);
        chk("t1_latency", done_cyc - s_cyc, 65);
        chk("t1_beats", beat_cnt - b0, 32);
        chk("t1_r2", seen[2], 32'h2ffc);
        chk("t1_r3", seen[3], 32'h1800);
        chk("t1_r0", seen[0], 0);
        chk("t1_r31", seen[31], 0);

        // narrow range instance, second start during the dump must be ignored
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick(); tick();
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int i = 0; i < 50 && done2_cnt == 0; i++) tick();
        repeat (12) tick();
        chk("t5_beats", b2_n, 2);
        chk("t5_addr0", b2_addr[0], 2); chk("t5_data0", b2_data[0], 32'h2ffc); chk("t5_last0", b2_last[0], 0);
        chk("t5_addr1", b2_addr[1], 3); chk("t5_data1", b2_data[1], 32'h1800); chk("t5_last1", b2_last[1], 1);
        chk("t5_done_once", done2_cnt, 1);
        chk("t5_idle", busy2, 0);

        // asynchronous reset mid-dump
        pulse_start();
        repeat (20) tick();
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("t4_busy", busy, 0);   chk("t4_valid", out_valid, 0);
        chk("t4_last", out_last, 0); chk("t4_ra", dbg_ra, 0);
        chk("t4_addr", out_addr, 0); chk("t4_data", out_data, 0);
        chk("t4_done", done, 0);
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        chk("t4_no_done", done_cnt, d0);
        b0 = beat_cnt;
        pulse_start();
        wait_done("t4_done_seen", 200);
        chk("t4_beats", beat_cnt - b0, 32);

        // preloaded RF, sink ready one cycle in three
        for (int k = 1; k < 32; k++) rf[k] = 32'hA5000000 + k;
        rmode = 1;
        b0 = beat_cnt;
        pulse_start();
        wait_done("t2_done_seen", 400);
        chk("t2_beats", beat_cnt - b0, 32);
        chk("t2_r17", seen[17], 32'hA5000011);
        chk("t2_r31", seen[31], 32'hA500001F);
        chk("t2_r0", seen[0], 0);

        // RF write after the LOAD of r5 is not reflected until the next dump
        rmode = 0;
        tick();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && !out_valid && dbg_ra == 5) begin ok = 1'b1; break; end
            tick();
        end
        chk("t6_reach_load5", ok, 1);
        tick();
        rf[5] = 32'h1234;
        wait_done("t6_done_seen", 200);
        chk("t6_old", seen[5], 32'hA5000005);
        pulse_start();
        wait_done("t6b_done_seen", 200);
        chk("t6_new", seen[5], 32'h1234);

        // abort in SEND at addr 10, coinciding with a handshake
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_addr == 10) begin ok = 1'b1; break; end
            tick();
        end
        chk("t3_reach_send10", ok, 1);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_valid", out_valid, 0);
        chk("t3_busy", busy, 0);
        repeat (8) tick();
        chk("t3_no_done", done_cnt, d0);
        b0 = beat_cnt;
        pulse_start();
        for (int i = 0; i < 20 && beat_cnt == b0; i++) tick();
        chk("t3_restart_addr", last_addr, 0);
        wait_done("t3_done_seen", 200);

        // randomized RF contents, sink readiness, start and abort
        rmode = 2;
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k < 32; k++) rf[k] = $urandom;
            for (int i = 0; i < 400; i++) begin
                start = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 59) == 0);
                tick();
            end
            start = 1'b0;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
